// File: rtl/positround_3_raw_pkg.sv
// Shared posit<32,2> definitions: raw adder-sum payload layout and special encodings.
package posit_defines;

  localparam int unsigned ABITS                          = 30;
  localparam int unsigned POSIT_N                        = 32;
  localparam int unsigned SCALE_W                        = 8;
  localparam int unsigned POSIT_SERIALIZED_WIDTH_SUM_ES2 = 1 + SCALE_W + ABITS + 2;

  // Packing window: 2 regime seed bits, 2 exponent bits, fraction, and zero pad
  // wide enough that the largest regime shift never pushes data off the end.
  localparam int unsigned PAD_W     = 32;
  localparam int unsigned PACK_W    = 2 + 2 + ABITS + PAD_W;
  localparam int unsigned MAG_W     = POSIT_N - 1;
  localparam int unsigned GUARD_IDX = PACK_W - MAG_W - 1;
  localparam int unsigned SHAMT_W   = 5;

  localparam logic signed [SCALE_W-1:0] SCALE_SAT_HI = 8'sd120;
  localparam logic signed [SCALE_W-1:0] SCALE_SAT_LO = -8'sd120;

  localparam logic [POSIT_N-1:0] POSIT_MAXPOS_32 = 32'h7FFF_FFFF;
  localparam logic [POSIT_N-1:0] POSIT_MINPOS_32 = 32'h0000_0001;
  localparam logic [POSIT_N-1:0] POSIT_NAR_32    = 32'h8000_0000;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [ABITS-1:0]          fraction;
    logic                      inf;
    logic                      zero;
  } value_sum;

endpackage

// File: rtl/positround_3_raw_if.sv
// Operand/result bundle between the posit adder back end and the rounding pipeline.
interface positround_3_raw_if;
  import posit_defines::*;

  value_sum             in_sum;
  logic                 in_truncated;
  logic                 start;
  logic [POSIT_N-1:0]   result;
  logic                 done;
  logic                 inexact;

  modport master (output in_sum, in_truncated, start, input result, done, inexact);
  modport slave  (input in_sum, in_truncated, start, output result, done, inexact);

endinterface

// File: rtl/positround_3_raw_shift_right.sv
// Right shift with a selectable fill bit entering from the MSB side.
module shift_right #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned SHW   = 5
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_ones;

  assign w_ones = '1;
  assign o_data = (i_data >> i_shamt) | ({WIDTH{i_fill}} & ~(w_ones >> i_shamt));

endmodule

// File: rtl/positround_3_raw.sv
// Three-stage posit<32,2> encoder: regime/exponent/fraction packing, RNE rounding,
// sign application. Fixed latency of three cycles, one operand per cycle, no stall.
module positround_3_raw
  import posit_defines::*;
(
  input  logic                     clk,
  input  logic                     rst,
  positround_3_raw_if.slave        bus
);

  // Stage 1 decode of the incoming sum
  logic signed [SCALE_W-1:0] w_scale;
  logic signed [5:0]         w_k;
  logic                      w_sathi;
  logic                      w_satlo;

  assign w_scale = $signed(bus.in_sum.scale);
  assign w_k     = 6'(w_scale >>> 2);
  assign w_sathi = (w_scale >= SCALE_SAT_HI);
  assign w_satlo = (w_scale <= SCALE_SAT_LO);

  logic              r_v1, r_sgn1, r_inf1, r_zero1, r_sathi1, r_satlo1, r_trunc1;
  logic signed [5:0] r_k1;
  logic [1:0]        r_e1;
  logic [ABITS-1:0]  r_frac1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_sgn1   <= 1'b0;
      r_inf1   <= 1'b0;
      r_zero1  <= 1'b0;
      r_sathi1 <= 1'b0;
      r_satlo1 <= 1'b0;
      r_trunc1 <= 1'b0;
      r_k1     <= '0;
      r_e1     <= '0;
      r_frac1  <= '0;
    end else begin
      // Written as an if so an unknown start falls through as "no operand"
      r_v1 <= 1'b0;
      if (bus.start) r_v1 <= 1'b1;
      r_sgn1   <= bus.in_sum.sgn;
      r_inf1   <= bus.in_sum.inf;
      r_zero1  <= bus.in_sum.zero;
      r_sathi1 <= w_sathi;
      r_satlo1 <= w_satlo;
      r_trunc1 <= bus.in_truncated;
      r_k1     <= w_k;
      r_e1     <= bus.in_sum.scale[1:0];
      r_frac1  <= bus.in_sum.fraction;
    end
  end

  // Stage 2: seed 10 (k>=0, fill ones) or 01 (k<0, fill zeros), shift by k or -k-1
  logic                 w_neg;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [PACK_W-1:0]    w_pack_in;
  logic [PACK_W-1:0]    w_pack;
  logic [MAG_W-1:0]     w_mag;
  logic                 w_guard, w_sticky, w_rup;
  logic [MAG_W:0]       w_sum;
  logic [MAG_W-1:0]     w_round;

  assign w_neg     = r_k1[5];
  assign w_shamt   = w_neg ? SHAMT_W'(~r_k1) : SHAMT_W'(r_k1);
  assign w_pack_in = {(w_neg ? 2'b01 : 2'b10), r_e1, r_frac1, {PAD_W{1'b0}}};

  shift_right #(.WIDTH(PACK_W), .SHW(SHAMT_W)) u_shift (
    .i_data  (w_pack_in),
    .i_shamt (w_shamt),
    .i_fill  (~w_neg),
    .o_data  (w_pack)
  );

  assign w_mag    = w_pack[PACK_W-1 -: MAG_W];
  assign w_guard  = w_pack[GUARD_IDX];
  assign w_sticky = (|w_pack[GUARD_IDX-1:0]) | r_trunc1;
  assign w_rup    = w_guard & (w_sticky | w_mag[0]);
  assign w_sum    = {1'b0, w_mag} + (MAG_W+1)'(w_rup);

  // Rounding may neither overflow past maxpos nor collapse to zero
  always_comb begin
    w_round = w_sum[MAG_W-1:0];
    if (w_sum[MAG_W])               w_round = POSIT_MAXPOS_32[MAG_W-1:0];
    else if (w_sum[MAG_W-1:0] == '0) w_round = POSIT_MINPOS_32[MAG_W-1:0];
  end

  logic             r_v2, r_sgn2, r_inx2, r_inf2, r_zero2, r_sathi2, r_satlo2;
  logic [MAG_W-1:0] r_mag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_sgn2   <= 1'b0;
      r_inx2   <= 1'b0;
      r_inf2   <= 1'b0;
      r_zero2  <= 1'b0;
      r_sathi2 <= 1'b0;
      r_satlo2 <= 1'b0;
      r_mag2   <= '0;
    end else begin
      r_v2     <= r_v1;
      r_sgn2   <= r_sgn1;
      r_inx2   <= w_guard | w_sticky;
      r_inf2   <= r_inf1;
      r_zero2  <= r_zero1;
      r_sathi2 <= r_sathi1;
      r_satlo2 <= r_satlo1;
      r_mag2   <= w_round;
    end
  end

  // Stage 3: special-case priority, then sign application
  logic [POSIT_N-1:0] w_abs, w_out;
  logic               w_inx;

  always_comb begin
    w_abs = {1'b0, r_mag2};
    w_inx = r_inx2;
    if (r_sathi2) begin
      w_abs = POSIT_MAXPOS_32;
      w_inx = 1'b1;
    end else if (r_satlo2) begin
      w_abs = POSIT_MINPOS_32;
      w_inx = 1'b1;
    end
    w_out = r_sgn2 ? (~w_abs + POSIT_N'(1)) : w_abs;
    if (r_inf2) begin
      w_out = POSIT_NAR_32;
      w_inx = 1'b0;
    end else if (r_zero2) begin
      w_out = '0;
      w_inx = 1'b0;
    end
  end

  logic               r_done, r_inexact;
  logic [POSIT_N-1:0] r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_inexact <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= r_v2;
      if (r_v2) begin
        r_result  <= w_out;
        r_inexact <= w_inx;
      end
    end
  end

  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.inexact = r_inexact;

endmodule

// File: tb/tb_positround_3_raw.sv
// Scoreboard bench for positround_3_raw: directed operands push expectations,
// a negedge monitor pops and compares on every done and checks output hold otherwise.
module tb_positround_3_raw;
  import posit_defines::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  positround_3_raw_if bus_if ();

  positround_3_raw u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare on done, otherwise outputs must hold the last completed value
  logic [31:0] last_res = '0;
  logic        last_inx = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
      last_inx = 1'b0;
    end else if (bus_if.done) begin
      if (q.size() == 0) begin
        check("done_without_operand", 32'(bus_if.done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", bus_if.result, e.res);
        check("inexact", 32'(bus_if.inexact), 32'(e.inx));
        check("latency", 32'(cyc - e.cyc), 32'd3);
        last_res = e.res;
        last_inx = e.inx;
      end
    end else begin
      check("hold_result", bus_if.result, last_res);
      check("hold_inexact", 32'(bus_if.inexact), 32'(last_inx));
    end
  end

  task automatic issue(input logic sgn, input logic [7:0] sc, input logic [29:0] fr,
                       input logic inf, input logic zero, input logic tr,
                       input logic [31:0] er, input logic ei, input bit push);
    value_sum v;
    v.sgn      = sgn;
    v.scale    = sc;
    v.fraction = fr;
    v.inf      = inf;
    v.zero     = zero;
    bus_if.in_sum       = v;
    bus_if.in_truncated = tr;
    bus_if.start        = 1'b1;
    if (push) q.push_back('{er, ei, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_if.start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus_if.start        = 1'b0;
    bus_if.in_sum       = '0;
    bus_if.in_truncated = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(bus_if.done), 32'd0);
    check("reset_result", bus_if.result, 32'd0);
    check("reset_inexact", 32'(bus_if.inexact), 32'd0);
    rst = 1'b0;
    idle(2);

    // Back-to-back stream:        sgn  scale    fraction       inf  zero tr  expected        inx
    issue(1'b0, 8'd0,    30'h0,          1'b0,1'b0,1'b0, 32'h4000_0000, 1'b0, 1'b1);
    issue(1'b1, 8'd1,    30'h0,          1'b0,1'b0,1'b0, 32'hB800_0000, 1'b0, 1'b1);
    issue(1'b0, 8'd0,    30'h4,          1'b0,1'b0,1'b0, 32'h4000_0000, 1'b1, 1'b1);
    issue(1'b0, 8'd0,    30'h4,          1'b0,1'b0,1'b1, 32'h4000_0001, 1'b1, 1'b1);
    issue(1'b0, 8'd0,    30'hC,          1'b0,1'b0,1'b0, 32'h4000_0002, 1'b1, 1'b1);
    issue(1'b0, 8'd0,    30'h3FFF_FFF8,  1'b0,1'b0,1'b0, 32'h47FF_FFFF, 1'b0, 1'b1);
    issue(1'b0, 8'd0,    30'h3FFF_FFFC,  1'b0,1'b0,1'b0, 32'h4800_0000, 1'b1, 1'b1);
    issue(1'b1, 8'd0,    30'h0,          1'b0,1'b0,1'b0, 32'hC000_0000, 1'b0, 1'b1);
    issue(1'b0, 8'hFF,   30'h0,          1'b0,1'b0,1'b0, 32'h3800_0000, 1'b0, 1'b1);
    issue(1'b0, 8'hF8,   30'h0,          1'b0,1'b0,1'b0, 32'h1000_0000, 1'b0, 1'b1);
    issue(1'b0, 8'd8,    30'h0,          1'b0,1'b0,1'b0, 32'h7000_0000, 1'b0, 1'b1);
    issue(1'b0, 8'd120,  30'h0,          1'b0,1'b0,1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'd127,  30'h0,          1'b0,1'b0,1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'h88,   30'h0,          1'b0,1'b0,1'b0, 32'h0000_0001, 1'b1, 1'b1);
    issue(1'b0, 8'h80,   30'h0,          1'b0,1'b0,1'b0, 32'h0000_0001, 1'b1, 1'b1);
    issue(1'b1, 8'd120,  30'h0,          1'b0,1'b0,1'b0, 32'h8000_0001, 1'b1, 1'b1);
    issue(1'b1, 8'h88,   30'h0,          1'b0,1'b0,1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'd119,  30'h0,          1'b0,1'b0,1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(1'b0, 8'h89,   30'h0,          1'b0,1'b0,1'b0, 32'h0000_0001, 1'b1, 1'b1);
    issue(1'b0, 8'd116,  30'h0,          1'b0,1'b0,1'b0, 32'h7FFF_FFFE, 1'b0, 1'b1);
    issue(1'b0, 8'h8C,   30'h0,          1'b0,1'b0,1'b0, 32'h0000_0002, 1'b0, 1'b1);
    issue(1'b1, 8'd5,    30'h0,          1'b1,1'b0,1'b1, 32'h8000_0000, 1'b0, 1'b1);
    issue(1'b1, 8'd3,    30'h5,          1'b0,1'b1,1'b1, 32'h0000_0000, 1'b0, 1'b1);
    issue(1'b0, 8'd0,    30'h0,          1'b1,1'b1,1'b0, 32'h8000_0000, 1'b0, 1'b1);
    issue(1'b0, 8'd127,  30'h0,          1'b0,1'b1,1'b0, 32'h0000_0000, 1'b0, 1'b1);

    // Isolated operands so the monitor sees hold cycles between results
    idle(1);
    issue(1'b0, 8'd4,    30'h0,          1'b0,1'b0,1'b0, 32'h6000_0000, 1'b0, 1'b1);
    idle(5);
    issue(1'b1, 8'd0,    30'h4,          1'b0,1'b0,1'b1, 32'hBFFF_FFFF, 1'b1, 1'b1);
    idle(5);

    // Unknown start must not launch an operand
    bus_if.start = 1'bx;
    @(posedge clk);
    #1;
    idle(5);

    // Two operands in flight are discarded by reset
    issue(1'b0, 8'd8,    30'h0,          1'b0,1'b0,1'b0, 32'h7000_0000, 1'b0, 1'b0);
    issue(1'b0, 8'd1,    30'h0,          1'b0,1'b0,1'b0, 32'h4800_0000, 1'b0, 1'b0);
    bus_if.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_clears_result", bus_if.result, 32'd0);
    check("rst_clears_done", 32'(bus_if.done), 32'd0);
    rst = 1'b0;
    idle(6);
    issue(1'b0, 8'd4,    30'h0,          1'b0,1'b0,1'b0, 32'h6000_0000, 1'b0, 1'b1);
    idle(1);

    begin
      int budget = 0;
      while (q.size() != 0 && budget < 50) begin
        @(posedge clk);
        budget++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
